branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 90 +++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters. The lookup path is combinational.
// Updates are resolved in EX and become visible on the next cycle. Resolved and mispredicted branches are counted.
module branch_predictor #(
  parameter int ENTRY_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic [31:0] PredPCF,
  output logic        BTBHitF,
  output logic        PredTakenF,
  input  logic        UpdEnE,
  input  logic [31:0] PCE,
  input  logic        TakenE,
  input  logic [31:0] TargetE,
  input  logic [31:0] PredPCE,
  output logic        MispredE,
  output logic [31:0] BrCnt,
  output logic [31:0] MissCnt
);

  localparam int ENTRIES = 1 << ENTRY_BITS;
  localparam int TAG_W   = 32 - ENTRY_BITS - 2;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];
  logic [31:0]        r_br_cnt;
  logic [31:0]        r_miss_cnt;

  logic [ENTRY_BITS-1:0] w_f_idx;
  logic [ENTRY_BITS-1:0] w_e_idx;
  logic [TAG_W-1:0]      w_f_tag;
  logic [TAG_W-1:0]      w_e_tag;
  logic                  w_e_hit;
  logic [31:0]           w_actual_npc;
  logic                  w_unused;

  assign w_f_idx  = PCF[ENTRY_BITS+1:2];
  assign w_f_tag  = PCF[31:ENTRY_BITS+2];
  assign w_e_idx  = PCE[ENTRY_BITS+1:2];
  assign w_e_tag  = PCE[31:ENTRY_BITS+2];
  assign w_unused = &{1'b0, PCF[1:0], PCE[1:0]};

  always_comb begin
    BTBHitF    = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    PredTakenF = BTBHitF && r_ctr[w_f_idx][1];
    PredPCF    = PredTakenF ? r_target[w_f_idx] : PCF + 32'd4;
  end

  always_comb begin
    w_e_hit      = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);
    w_actual_npc = TakenE ? TargetE : PCE + 32'd4;
    MispredE     = UpdEnE && (w_actual_npc != PredPCE);
  end

  // Tag/target need no reset; a taken resolve always (re)writes them, on a hit the tag is unchanged.
  always_ff @(posedge clk) begin
    if (!rst && UpdEnE && TakenE) begin
      r_tag[w_e_idx]    <= w_e_tag;
      r_target[w_e_idx] <= TargetE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_ctr      <= '{default: 2'b01};
      r_br_cnt   <= '0;
      r_miss_cnt <= '0;
    end else if (UpdEnE) begin
      r_br_cnt <= r_br_cnt + 32'd1;
      if (MispredE) r_miss_cnt <= r_miss_cnt + 32'd1;
      if (w_e_hit) begin
        if (TakenE && r_ctr[w_e_idx] != 2'b11)
          r_ctr[w_e_idx] <= r_ctr[w_e_idx] + 2'd1;
        else if (!TakenE && r_ctr[w_e_idx] != 2'b00)
          r_ctr[w_e_idx] <= r_ctr[w_e_idx] - 2'd1;
      end else if (TakenE) begin
        r_valid[w_e_idx] <= 1'b1;
        r_ctr[w_e_idx]   <= 2'b10;
      end
    end
  end

  assign BrCnt   = r_br_cnt;
  assign MissCnt = r_miss_cnt;

endmodule
